pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/freeze controller with performance counters
module pipe_ctrl #(
  parameter logic [7:0] RNONE = 8'hF,
  parameter int         CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [7:0]       d_icode_i,
  input  logic [7:0]       d_srcA_i,
  input  logic [7:0]       d_srcB_i,
  input  logic [7:0]       e_icode_i,
  input  logic [7:0]       e_dstM_i,
  input  logic             e_cnd_i,
  input  logic [7:0]       m_icode_i,
  input  logic [7:0]       w_icode_i,
  input  logic             hold_req_i,
  input  logic             clr_cnt_i,
  output logic             f_stall_o,
  output logic             d_stall_o,
  output logic             w_stall_o,
  output logic             d_bubble_o,
  output logic             e_bubble_o,
  output logic             m_bubble_o,
  output logic             hold_ack_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] bub_cnt_o
);

  localparam logic [7:0] I_HALT   = 8'h0;
  localparam logic [7:0] I_MRMOVL = 8'h5;
  localparam logic [7:0] I_JXX    = 8'h7;
  localparam logic [7:0] I_RET    = 8'h9;
  localparam logic [7:0] I_POPL   = 8'hB;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_HOLD   = 2'd1,
    S_HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             hold_ack_q, halted_q;
  logic [CNT_W-1:0] cyc_cnt_q, stall_cnt_q, bub_cnt_q;

  logic load_use, ret_in, mispred;
  logic run_f_stall, run_d_stall, run_d_bubble, run_e_bubble;
  logic in_run;

  // Hazard detection on the current decode/execute/memory contents
  always_comb begin
    load_use = ((e_icode_i == I_MRMOVL) || (e_icode_i == I_POPL)) &&
               (e_dstM_i != RNONE) &&
               ((e_dstM_i == d_srcA_i) || (e_dstM_i == d_srcB_i));
    ret_in   = (d_icode_i == I_RET) || (e_icode_i == I_RET) || (m_icode_i == I_RET);
    mispred  = (e_icode_i == I_JXX) && !e_cnd_i;
  end

  // Running-pipeline control; load-use takes priority over squashing decode
  always_comb begin
    run_f_stall  = load_use | ret_in;
    run_d_stall  = load_use;
    run_d_bubble = !load_use & (mispred | ret_in);
    run_e_bubble = mispred | load_use;
  end

  assign in_run = (state_q == S_RUN);

  // Freeze everything in HOLD/HALTED; m_bubble keeps a held store from repeating
  always_comb begin
    if (in_run) begin
      f_stall_o  = run_f_stall;
      d_stall_o  = run_d_stall;
      w_stall_o  = 1'b0;
      d_bubble_o = run_d_bubble;
      e_bubble_o = run_e_bubble;
      m_bubble_o = 1'b0;
    end else begin
      f_stall_o  = 1'b1;
      d_stall_o  = 1'b1;
      w_stall_o  = 1'b1;
      d_bubble_o = 1'b0;
      e_bubble_o = 1'b0;
      m_bubble_o = 1'b1;
    end
  end

  // Next-state: a retiring HALT beats a freeze request; HALTED only exits via reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN: begin
        if (w_icode_i == I_HALT) state_d = S_HALTED;
        else if (hold_req_i)     state_d = S_HOLD;
      end
      S_HOLD: begin
        if (w_icode_i == I_HALT) state_d = S_HALTED;
        else if (!hold_req_i)    state_d = S_RUN;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_RUN;
    endcase
  end

  // State register with status flags registered alongside it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_RUN;
      hold_ack_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_ack_q <= (state_d == S_HOLD);
      halted_q   <= (state_d == S_HALTED);
    end
  end

  // Performance counters; clear wins over any increment in the same cycle
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      bub_cnt_q   <= '0;
    end else if (clr_cnt_i) begin
      cyc_cnt_q   <= '0;
      stall_cnt_q <= '0;
      bub_cnt_q   <= '0;
    end else begin
      if (state_q != S_HALTED)
        cyc_cnt_q <= cyc_cnt_q + CNT_W'(1);
      if (in_run && run_f_stall)
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (in_run && (run_d_bubble || run_e_bubble))
        bub_cnt_q <= bub_cnt_q + CNT_W'(1);
    end
  end

  assign hold_ack_o  = hold_ack_q;
  assign halted_o    = halted_q;
  assign cyc_cnt_o   = cyc_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign bub_cnt_o   = bub_cnt_q;

endmodule
